wr_port_arbiter: RTL and testbench
==================================

# wr_port_arbiter

Round-robin arbiter sharing the single write port of the asynchronous FIFO among `NUM_REQ` write-domain requesters. Grants one requester at a time for a burst, which lasts up to `MAX_BURST` beats or until a `req_last` beat. It drives the FIFO `winc`/`wdata` and applies `wfull` backpressure to the granted requester. Sits entirely in the `wclk` domain, directly upstream of the FIFO write-pointer/full logic.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default 8: FIFO data width.
- `MAX_BURST`, default 4: maximum beats per grant, ≥1.

- `wclk`  in  1  write-domain clock; all state on rising edge.
- `wrst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester data valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  marks final beat of requester's packet.
- `req_ready`  out  NUM_REQ  beat accepted when `req_valid[i] & req_ready[i]`.
- `wfull`  in  1  FIFO full flag.
- `winc`  out  1  FIFO write enable.
- `wdata`  out  DATA_WIDTH  FIFO write data.
- `grant`  out  NUM_REQ  one-hot current owner, registered.
- `busy`  out  1  high in XFER state.

## Operation
- States: IDLE, XFER. Reset state IDLE.
- IDLE: if any `req_valid` is high, select winner i, register `grant` = 1<<i, clear `beat_cnt`, go to XFER. Otherwise stay in IDLE.
- Round-robin: `rr_ptr` (reset 0). Search starts at `rr_ptr` and ascends with wrap. On grant to i, `rr_ptr` ← (i+1) mod NUM_REQ.
- XFER, with owner g:
  - `req_ready[g]` = ~`wfull`; all other `req_ready` bits are 0.
  - `winc` = `req_valid[g]` & ~`wfull` (combinational, so the FIFO never drops a write).
  - `wdata` = `req_data` slice g.
- Beat accepted (`winc`=1): `beat_cnt`++.
- Exit to IDLE on an accepted beat that has `req_last[g]`=1 or `beat_cnt`==MAX_BURST-1. On exit, `grant` ← 0.
- The owner dropping `req_valid` mid-burst does not release the grant; the lock is held until exit.
- Outside XFER: `winc`=0, `wdata`=0, `req_ready`=0.
- `wfull` high in XFER: no beat is accepted and `beat_cnt` holds. There is no timeout.
- `beat_cnt` width is $clog2(MAX_BURST)+1.

## Timing
- Reset (asynchronous assert, immediate):
  - state IDLE; `grant`=0, `rr_ptr`=0, `beat_cnt`=0.
  - Outputs `winc`=0, `wdata`=0, `req_ready`=0, `busy`=0.
- Reset mid-burst aborts the burst; no partial state survives. Release is synchronous to the next `wclk`.
- Grant latency: `req_valid` sampled in IDLE at edge N gives `grant`/`busy` after edge N. The first beat can be written in the cycle after edge N.
- Throughput: 1 beat/cycle while not full. Each burst ends with exactly one IDLE cycle, so the best case is MAX_BURST beats per MAX_BURST+1 cycles.
- `wfull` to `winc` is same-cycle combinational. `winc` never asserts while `wfull`=1.
- Requests arriving during XFER wait for the next IDLE cycle.

## Configuration
- `WR_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins. `rr_ptr` is removed, and the search always starts at index 0.
- Not defined: round-robin as described above.

## Test plan
- Single requester 1, 3-beat packet (`req_last` on 3rd), FIFO not full:
  - `grant`=4'b0010 one cycle after request.
  - `winc` high for 3 consecutive cycles, `wdata` matches the beats.
  - IDLE on the following cycle.
- Requesters 0 and 2 continuously valid, no `req_last`, MAX_BURST=4:
  - Alternating 4-beat bursts 0,2,0,2.
  - One idle cycle between bursts.
  - `rr_ptr` sequence 1,3,1.
- `wfull` asserted for 5 cycles mid-burst after beat 2:
  - `winc`=0 and `req_ready`=0 for those 5 cycles; `beat_cnt` holds at 2.
  - Remaining beats resume with no loss or duplication.
- `wrst` pulsed mid-burst with 2 of 4 beats sent: `winc`, `grant`, `busy` and `req_ready` drop to 0 immediately, and `rr_ptr`=0.
- All four requesters valid:
  - With `WR_ARB_FIXED_PRIO_EN` defined: requester 0 is granted every burst.
  - Without it: grants rotate 0,1,2,3.
- Owner deasserts `req_valid` for 3 cycles mid-burst while requester 3 is valid:
  - Grant stays with the owner and no `winc` occurs in those 3 cycles.
  - Requester 3 is granted only after the owner's last beat.

Source files
------------

// File: rtl/wr_port_arbiter.sv
// Write-port arbiter sharing one async-FIFO write port among NUM_REQ requesters in bursts.
// Define WR_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module wr_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   beatCnt_q, beatCnt_d;
    logic [IDX_W-1:0]   searchStart;
    logic [IDX_W-1:0]   candIdx;
    logic [IDX_W-1:0]   winIdx;
    logic               found;
    logic               accept;
    logic               burstEnd;

    function automatic logic [IDX_W-1:0] wrapIdx(input logic [IDX_W:0] sum);
        if (sum >= NUM_REQ_W) begin
            return IDX_W'(sum - NUM_REQ_W);
        end
        return sum[IDX_W-1:0];
    endfunction

`ifdef WR_ARB_FIXED_PRIO_EN
    assign searchStart = '0;
`else
    logic [IDX_W-1:0] rrPtr_q, rrPtr_d;

    assign searchStart = rrPtr_q;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            rrPtr_q <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end

    always_comb begin
        rrPtr_d = rrPtr_q;
        if (state_q == IDLE && found) begin
            rrPtr_d = wrapIdx({1'b0, winIdx} + (IDX_W+1)'(1));
        end
    end
`endif

    // First valid requester at or after searchStart, wrapping around.
    always_comb begin
        found   = 1'b0;
        winIdx  = '0;
        candIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            candIdx = wrapIdx({1'b0, searchStart} + (IDX_W+1)'(k));
            if (!found && req_valid[candIdx]) begin
                found  = 1'b1;
                winIdx = candIdx;
            end
        end
    end

    assign accept   = (state_q == XFER) && req_valid[owner_q] && !wfull;
    assign burstEnd = req_last[owner_q] || (beatCnt_q == LAST_BEAT);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        beatCnt_d = beatCnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = XFER;
                    grant_d   = NUM_REQ'(1) << winIdx;
                    owner_d   = winIdx;
                    beatCnt_d = '0;
                end
            end
            XFER: begin
                // The lock is held while the owner idles; only an accepted beat can end it.
                if (accept) begin
                    beatCnt_d = beatCnt_q + CNT_W'(1);
                    if (burstEnd) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        winc      = 1'b0;
        wdata     = '0;
        req_ready = '0;
        if (state_q == XFER) begin
            winc               = accept;
            wdata              = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
            req_ready[owner_q] = !wfull;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == XFER);

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Randomized self-checking bench for wr_port_arbiter against a transaction-level burst model.
`timescale 1ns/1ps
module tb_wr_port_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            wclk = 1'b0;
    logic            wrst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            wfull = 1'b0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    grant;
    logic            winc;
    logic            busy;
    logic [DW-1:0]   wdata;

    int errors = 0;
    int checks = 0;

    // Model: owner index (-1 when idle), beats taken in this burst, next search start.
    int mOwner = -1;
    int mBeats = 0;
    int mRr    = 0;
    logic [3:0] srcSeq [N];

    logic [N-1:0]  eGrant, eReady;
    logic          eBusy, eWinc;
    logic [DW-1:0] eWdata;

    wr_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    function automatic logic [DW-1:0] srcWord(input int i);
        return {4'(i), srcSeq[i]};
    endfunction

    function automatic void computeExp();
        eGrant = '0;
        eReady = '0;
        eBusy  = 1'b0;
        eWinc  = 1'b0;
        eWdata = '0;
        if (mOwner >= 0) begin
            eBusy          = 1'b1;
            eGrant[mOwner] = 1'b1;
            eWdata         = srcWord(mOwner);
            eWinc          = req_valid[mOwner] && !wfull;
            eReady[mOwner] = !wfull;
        end
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        @(negedge wclk);
        req_valid = v;
        req_last  = l;
        wfull     = f;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = srcWord(i);
        #1;
        computeExp();
    endtask

    task automatic advance();
        int start;
        int c;
        if (mOwner < 0) begin
`ifdef WR_ARB_FIXED_PRIO_EN
            start = 0;
`else
            start = mRr;
`endif
            for (int k = 0; k < N; k++) begin
                c = (start + k) % N;
                if (req_valid[c]) begin
                    mOwner = c;
                    mBeats = 0;
                    mRr    = (c + 1) % N;
                    break;
                end
            end
        end else if (eWinc) begin
            srcSeq[mOwner] = srcSeq[mOwner] + 4'd1;
            mBeats++;
            if (req_last[mOwner] || mBeats == MB) mOwner = -1;
        end
        @(posedge wclk);
    endtask

    task automatic resetDut();
        @(negedge wclk);
        req_valid = '0;
        req_last  = '0;
        wfull     = 1'b0;
        wrst      = 1'b1;
        mOwner    = -1;
        mBeats    = 0;
        mRr       = 0;
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        #1 wrst = 1'b1;
        #2;
        checks++;
        if ({grant, busy, winc, wdata, req_ready} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state got=%h want=0", {grant, busy, winc, wdata, req_ready});
        end
        req_valid = '0;
        resetDut();
    endtask

    task automatic test_single();
        int acc = 0;
        int seenWinc = 0;
        logic [N-1:0] v, l;
        resetDut();
        for (int c = 0; c < 7; c++) begin
            v = (acc < 3) ? 4'b0010 : 4'b0000;
            l = (acc == 2) ? 4'b0010 : 4'b0000;
            drive(v, l, 1'b0);
            checks++;
            if ({grant, busy, winc, wdata, req_ready} !== {eGrant, eBusy, eWinc, eWdata, eReady}) begin
                errors++;
                $display("[TB] FAIL single cyc=%0d got=%h want=%h", c, {grant, busy, winc, wdata, req_ready}, {eGrant, eBusy, eWinc, eWdata, eReady});
            end
            if (c == 1) begin
                checks++;
                if (grant !== 4'b0010) begin
                    errors++;
                    $display("[TB] FAIL single_grant got=%b want=0010", grant);
                end
            end
            if (c == 4) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL single_idle_after got busy=%b want 0", busy);
                end
            end
            if (winc === 1'b1) seenWinc++;
            if (eWinc) acc++;
            advance();
        end
        checks++;
        if (seenWinc != 3) begin
            errors++;
            $display("[TB] FAIL single_beats got=%0d want=3", seenWinc);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] starts[$];
        logic [N-1:0] want [4];
        logic prevBusy = 1'b0;
        want = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        resetDut();
        for (int c = 0; c < 20; c++) begin
            drive(4'b0101, 4'b0000, 1'b0);
            checks++;
            if ({grant, busy, winc, wdata, req_ready} !== {eGrant, eBusy, eWinc, eWdata, eReady}) begin
                errors++;
                $display("[TB] FAIL round_robin cyc=%0d got=%h want=%h", c, {grant, busy, winc, wdata, req_ready}, {eGrant, eBusy, eWinc, eWdata, eReady});
            end
            if (busy === 1'b1 && !prevBusy) starts.push_back(grant);
            prevBusy = busy;
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (starts.size() <= i || starts[i] !== want[i]) begin
                errors++;
                $display("[TB] FAIL round_robin_order idx=%0d got=%b want=%b", i, (starts.size() > i) ? starts[i] : 4'bxxxx, want[i]);
            end
        end
    endtask

    task automatic test_wfull();
        int acc = 0;
        int fullLeft = 5;
        logic f;
        logic [DW-1:0] log_q[$];
        resetDut();
        for (int i = 0; i < N; i++) srcSeq[i] = 4'd0;
        for (int c = 0; c < 14; c++) begin
            f = (acc == 2 && fullLeft > 0);
            drive((acc < 4) ? 4'b0001 : 4'b0000, 4'b0000, f);
            checks++;
            if ({grant, busy, winc, wdata, req_ready} !== {eGrant, eBusy, eWinc, eWdata, eReady}) begin
                errors++;
                $display("[TB] FAIL wfull cyc=%0d got=%h want=%h", c, {grant, busy, winc, wdata, req_ready}, {eGrant, eBusy, eWinc, eWdata, eReady});
            end
            if (f) begin
                fullLeft--;
                checks++;
                if (winc !== 1'b0 || req_ready !== '0) begin
                    errors++;
                    $display("[TB] FAIL wfull_block got winc=%b ready=%b want 0/0000", winc, req_ready);
                end
            end
            if (winc === 1'b1) log_q.push_back(wdata);
            if (eWinc) acc++;
            advance();
        end
        checks++;
        if (log_q.size() != 4) begin
            errors++;
            $display("[TB] FAIL wfull_count got=%0d want=4", log_q.size());
        end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== DW'(i)) begin
                errors++;
                $display("[TB] FAIL wfull_data idx=%0d got=%h want=%h", i, log_q[i], DW'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        int c = 0;
        resetDut();
        while (acc < 2 && c < 10) begin
            drive(4'b0001, 4'b0000, 1'b0);
            checks++;
            if ({grant, busy, winc, wdata, req_ready} !== {eGrant, eBusy, eWinc, eWdata, eReady}) begin
                errors++;
                $display("[TB] FAIL reset_mid_pre cyc=%0d got=%h want=%h", c, {grant, busy, winc, wdata, req_ready}, {eGrant, eBusy, eWinc, eWdata, eReady});
            end
            if (eWinc) acc++;
            advance();
            c++;
        end
        checks++;
        if (acc < 2) begin
            errors++;
            $display("[TB] FAIL reset_mid_timeout got beats=%0d want 2", acc);
        end
        @(negedge wclk);
        #2 wrst = 1'b1;
        #1;
        checks++;
        if ({winc, grant, busy, req_ready} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_drop got=%h want=0", {winc, grant, busy, req_ready});
        end
        req_valid = '0;
        mOwner = -1;
        mBeats = 0;
        mRr    = 0;
        @(negedge wclk);
        wrst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(4'b1001, 4'b0000, 1'b0);
            checks++;
            if ({grant, busy, winc, wdata, req_ready} !== {eGrant, eBusy, eWinc, eWdata, eReady}) begin
                errors++;
                $display("[TB] FAIL reset_mid_post cyc=%0d got=%h want=%h", k, {grant, busy, winc, wdata, req_ready}, {eGrant, eBusy, eWinc, eWdata, eReady});
            end
            if (k == 1) begin
                checks++;
                if (grant !== 4'b0001) begin
                    errors++;
                    $display("[TB] FAIL reset_mid_rrptr got grant=%b want=0001", grant);
                end
            end
            advance();
        end
    endtask

    task automatic test_rotate_all();
        logic [N-1:0] starts[$];
        logic [N-1:0] want [4];
        logic prevBusy = 1'b0;
`ifdef WR_ARB_FIXED_PRIO_EN
        want = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
        resetDut();
        for (int c = 0; c < 20; c++) begin
            drive(4'b1111, 4'b0000, 1'b0);
            checks++;
            if ({grant, busy, winc, wdata, req_ready} !== {eGrant, eBusy, eWinc, eWdata, eReady}) begin
                errors++;
                $display("[TB] FAIL rotate_all cyc=%0d got=%h want=%h", c, {grant, busy, winc, wdata, req_ready}, {eGrant, eBusy, eWinc, eWdata, eReady});
            end
            if (busy === 1'b1 && !prevBusy) starts.push_back(grant);
            prevBusy = busy;
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (starts.size() <= i || starts[i] !== want[i]) begin
                errors++;
                $display("[TB] FAIL rotate_all_order idx=%0d got=%b want=%b", i, (starts.size() > i) ? starts[i] : 4'bxxxx, want[i]);
            end
        end
    endtask

    task automatic test_lock();
        int acc = 0;
        int dropLeft = 3;
        logic drop;
        logic [N-1:0] starts[$];
        logic prevBusy = 1'b0;
        resetDut();
        for (int c = 0; c < 14; c++) begin
            drop = (acc == 1 && dropLeft > 0);
            drive({1'b1, 2'b00, (acc < 4) && !drop}, 4'b0000, 1'b0);
            checks++;
            if ({grant, busy, winc, wdata, req_ready} !== {eGrant, eBusy, eWinc, eWdata, eReady}) begin
                errors++;
                $display("[TB] FAIL lock cyc=%0d got=%h want=%h", c, {grant, busy, winc, wdata, req_ready}, {eGrant, eBusy, eWinc, eWdata, eReady});
            end
            if (drop) begin
                dropLeft--;
                checks++;
                if (grant !== 4'b0001 || winc !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL lock_hold got grant=%b winc=%b want 0001/0", grant, winc);
                end
            end
            if (busy === 1'b1 && !prevBusy) starts.push_back(grant);
            prevBusy = busy;
            if (eWinc && mOwner == 0) acc++;
            advance();
        end
        checks++;
        if (starts.size() < 2 || starts[0] !== 4'b0001 || starts[1] !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL lock_order got first=%b second=%b want 0001 then 1000", (starts.size() > 0) ? starts[0] : 4'bxxxx, (starts.size() > 1) ? starts[1] : 4'bxxxx);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] v, l;
        logic f;
        resetDut();
        for (int c = 0; c < 400; c++) begin
            v = N'($urandom);
            l = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            f = ($urandom_range(0, 4) == 0);
            drive(v, l, f);
            checks++;
            if ({grant, busy, winc, wdata, req_ready} !== {eGrant, eBusy, eWinc, eWdata, eReady}) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d got=%h want=%h", c, {grant, busy, winc, wdata, req_ready}, {eGrant, eBusy, eWinc, eWdata, eReady});
            end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) srcSeq[i] = 4'(i * 3);
        test_reset();
        test_single();
        test_round_robin();
        test_wfull();
        test_reset_mid();
        test_rotate_all();
        test_lock();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
